// File: rtl/ras_pkg.sv
// Shared sizing constants and storage types for the return-address stack
// and its checkpoint table.
package ras_pkg;

    localparam int unsigned RAS_DEPTH = 16;
    localparam int unsigned RAS_PTRW  = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_WIDTH = 32;
    localparam int unsigned RAS_CNTW  = 7;
    localparam int unsigned RAS_NCKPT = 8;
    localparam int unsigned RAS_CKW   = $clog2(RAS_NCKPT);

    typedef struct packed {
        logic [RAS_CNTW-1:0]  cnt;
        logic [RAS_WIDTH-1:0] addr;
    } ras_entry_t;

    typedef struct packed {
        logic [RAS_PTRW-1:0] ptr;
        logic [RAS_PTRW:0]   occ;
        ras_entry_t          top;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_stack_if.sv
// Predictor-side request/status bundle of the return-address stack:
// push/pop from fetch, checkpoint save/restore from the backend.
interface ras_ckpt_stack_if #(
    parameter int unsigned WIDTH = ras_pkg::RAS_WIDTH,
    parameter int unsigned CKW   = ras_pkg::RAS_CKW
);
    logic             PushEn;
    logic [WIDTH-1:0] PushAddr;
    logic             PopEn;
    logic [WIDTH-1:0] TopAddr;
    logic             TopValid;
    logic             Full;
    logic             Empty;
    logic             Underflow;
    logic             CkptSave;
    logic [CKW-1:0]   CkptSaveId;
    logic             CkptRestore;
    logic [CKW-1:0]   CkptRestoreId;

    modport master (
        output PushEn, PushAddr, PopEn, CkptSave, CkptSaveId, CkptRestore, CkptRestoreId,
        input  TopAddr, TopValid, Full, Empty, Underflow
    );

    modport slave (
        input  PushEn, PushAddr, PopEn, CkptSave, CkptSaveId, CkptRestore, CkptRestoreId,
        output TopAddr, TopValid, Full, Empty, Underflow
    );
endinterface

// File: rtl/ras_ckpt_table.sv
// Checkpoint register file: one synchronous write port, one asynchronous
// read port, cleared by the asynchronous reset.
module ras_ckpt_table
    import ras_pkg::*;
#(
    parameter int unsigned NCKPT = RAS_NCKPT,
    parameter int unsigned CKW   = RAS_CKW
) (
    input  logic           Clk,
    input  logic           Rest,
    input  logic           WrEn,
    input  logic [CKW-1:0] WrId,
    input  ras_ckpt_t      WrData,
    input  logic [CKW-1:0] RdId,
    output ras_ckpt_t      RdData
);

    ras_ckpt_t slots [NCKPT];

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int unsigned i = 0; i < NCKPT; i++) begin
                slots[i] <= '0;
            end
        end else if (WrEn) begin
            slots[WrId] <= WrData;
        end
    end

    // Read sees pre-edge contents, so a same-ID save+restore restores the old slot.
    assign RdData = slots[RdId];

endmodule

// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with recursion counters and a checkpoint
// table for single-cycle mispredict recovery.
module ras_ckpt_stack
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned PTRW  = RAS_PTRW,
    parameter int unsigned WIDTH = RAS_WIDTH,
    parameter int unsigned CNTW  = RAS_CNTW,
    parameter int unsigned NCKPT = RAS_NCKPT,
    parameter int unsigned CKW   = RAS_CKW
) (
    input  logic              Clk,
    input  logic              Rest,
    ras_ckpt_stack_if.slave   bus
);

    localparam logic [PTRW:0]   OCC_FULL = (PTRW+1)'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    ras_entry_t       entries   [DEPTH];
    ras_entry_t       entries_n [DEPTH];
    logic [PTRW-1:0]  ptr, ptr_n;
    logic [PTRW:0]    occ, occ_n;
    logic             underflow, underflow_n;
    logic [PTRW-1:0]  top_idx, post_idx, rst_idx, save_idx;
    logic [WIDTH-1:0] top_addr;
    ras_ckpt_t        rd_ckpt, save_ckpt;

    assign top_idx = ptr - 1'b1;
    assign rst_idx = rd_ckpt.ptr - 1'b1;

    // Restore overrides everything; otherwise pop is applied first and push sees the post-pop stack.
    always_comb begin
        entries_n   = entries;
        ptr_n       = ptr;
        occ_n       = occ;
        underflow_n = 1'b0;
        post_idx    = top_idx;

        if (bus.CkptRestore) begin
            ptr_n = rd_ckpt.ptr;
            occ_n = rd_ckpt.occ;
            if (rd_ckpt.occ != '0) begin
                entries_n[rst_idx] = rd_ckpt.top;
            end
        end else begin
            if (bus.PopEn) begin
                if (occ == '0) begin
                    underflow_n = 1'b1;
                end else if (entries[top_idx].cnt > CNT_ONE) begin
                    entries_n[top_idx].cnt = entries[top_idx].cnt - 1'b1;
                end else begin
                    entries_n[top_idx] = '0;
                    ptr_n              = top_idx;
                    occ_n              = occ - 1'b1;
                end
            end

            post_idx = ptr_n - 1'b1;
            if (bus.PushEn) begin
                if (occ_n != '0 && entries_n[post_idx].addr == bus.PushAddr &&
                    entries_n[post_idx].cnt != CNT_MAX) begin
                    entries_n[post_idx].cnt = entries_n[post_idx].cnt + 1'b1;
                end else begin
                    entries_n[ptr_n] = '{cnt: CNT_ONE, addr: bus.PushAddr};
                    ptr_n            = ptr_n + 1'b1;
                    if (occ_n != OCC_FULL) begin
                        occ_n = occ_n + 1'b1;
                    end
                end
            end
        end
    end

    assign save_idx      = ptr_n - 1'b1;
    assign save_ckpt.ptr = ptr_n;
    assign save_ckpt.occ = occ_n;
    assign save_ckpt.top = (occ_n != '0) ? entries_n[save_idx] : '0;

    ras_ckpt_table #(
        .NCKPT (NCKPT),
        .CKW   (CKW)
    ) u_ckpt_table (
        .Clk    (Clk),
        .Rest   (Rest),
        .WrEn   (bus.CkptSave),
        .WrId   (bus.CkptSaveId),
        .WrData (save_ckpt),
        .RdId   (bus.CkptRestoreId),
        .RdData (rd_ckpt)
    );

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            ptr       <= '0;
            occ       <= '0;
            underflow <= 1'b0;
        end else begin
            entries   <= entries_n;
            ptr       <= ptr_n;
            occ       <= occ_n;
            underflow <= underflow_n;
        end
    end

    assign top_addr      = entries[top_idx].addr;
    assign bus.TopAddr   = (occ != '0) ? top_addr : '0;
    assign bus.TopValid  = (occ != '0);
    assign bus.Full      = (occ == OCC_FULL);
    assign bus.Empty     = (occ == '0);
    assign bus.Underflow = underflow;

endmodule
